imem_boot_arbiter: RTL and testbench
====================================

Name: imem_boot_arbiter

Overview:
- Shares the single port of the instruction memory between the CPU instruction-fetch port and the UART boot loader write port.
- Sequences ownership handover:
  - drains outstanding CPU fetches before granting the boot loader;
  - buffers boot writes that arrive during the drain;
  - holds the CPU in reset until the boot image is fully written and a release delay has elapsed.
- Sits between the boot loader, the core's instruction bus, and the instruction RAM.

Parameters:
- AW, 32, address width.
- DW, 32, data width (byte-enable width DW/8).
- BUF_DEPTH, 4, boot write FIFO depth (power of 2, >=2).
- REL_CYC, 16, cycles CPU reset stays asserted after the boot buffer empties.

Ports:
- Clk  in  1  system clock.
- Rst  in  1  synchronous, active-high reset.
- boot_active  in  1  boot loader owns system (boot loader Rst_out).
- boot_req  in  1  one-cycle write strobe, no backpressure.
- boot_addr  in  AW  byte address.
- boot_wdata  in  DW  write data.
- boot_be  in  DW/8  byte enables.
- cpu_req  in  1  fetch request.
- cpu_addr  in  AW  fetch address.
- cpu_gnt  out  1  fetch accepted.
- cpu_rvalid  out  1  read data valid.
- cpu_rdata  out  DW  read data.
- mem_req  out  1  memory request.
- mem_we  out  1  write enable.
- mem_addr  out  AW  address.
- mem_wdata  out  DW  write data.
- mem_be  out  DW/8  byte enables.
- mem_rdata  in  DW  read data, valid 1 cycle after an accepted read.
- cpu_rst  out  1  reset to core, active-high.
- ovf_err  out  1  sticky boot FIFO overflow.
- wr_count  out  32  boot writes committed since entering BOOT.

Behaviour:
- Reset values:
  - state=CPU;
  - mem_req=0, mem_we=0, cpu_gnt=0, cpu_rvalid=0;
  - cpu_rst=1 for REL_CYC cycles after Rst deasserts (power-on release path is RELEASE);
  - FIFO empty, ovf_err=0, wr_count=0.
- Memory accepts every request in the cycle presented (no memory gnt).
- Boot write FIFO:
  - boot_req pushes {addr,wdata,be} in any state.
  - Push when full: drop the write, set ovf_err (cleared only by Rst).
  - Simultaneous push and pop when full is legal and does not overflow.
- States:
  - CPU:
    - cpu_gnt=cpu_req combinationally; mem driven from CPU, mem_we=0.
    - cpu_rvalid registered 1 cycle after the grant; cpu_rdata=mem_rdata.
    - boot_active=1 -> DRAIN (a request in that same cycle is still granted).
  - DRAIN:
    - cpu_gnt=0, cpu_rst=1.
    - Wait until no read is outstanding (the cycle after the last grant), then -> BOOT; latency 1 cycle.
    - Clear wr_count on entry to BOOT.
  - BOOT:
    - cpu_rst=1.
    - Each cycle FIFO non-empty: pop head, drive mem_req=1, mem_we=1, increment wr_count.
    - boot_active=0 -> FLUSH.
  - FLUSH:
    - Continue popping until the FIFO is empty, then -> RELEASE.
  - RELEASE:
    - Count REL_CYC cycles, cpu_rst=1.
    - On terminal count -> CPU; cpu_rst=0 the same cycle the state becomes CPU.
    - boot_active=1 during RELEASE or FLUSH -> BOOT (no drain needed; CPU idle).
    - wr_count is not cleared on that return.
- cpu_rst=1 in every state except CPU.
- Single-write boot burst: push in cycle n, memory write in cycle n+1 (FIFO is registered, first-word latency 1).
- wr_count wraps at 2^32.
- Rst mid-BOOT:
  - discards FIFO contents and any in-flight write;
  - the next cycle mem_req=0 and the RELEASE sequence restarts.

Decomposition:
- Shared package imem_arb_pkg:
  - state enum arb_state_t {CPU, DRAIN, BOOT, FLUSH, RELEASE};
  - packed struct boot_wr_t {addr, wdata, be}.
- One sub-module sync_fifo, parameterised by width and depth:
  - push/pop/full/empty;
  - registered data out.

Test Plan:
- Reset release: Rst for 3 cycles, then idle -> cpu_rst=1 for exactly 16 cycles after Rst falls, then 0; mem_req=0 throughout.
- CPU fetch: cpu_req at addr 0x100, mem_rdata=0xDEADBEEF -> cpu_gnt same cycle, cpu_rvalid=1 with rdata=0xDEADBEEF next cycle.
- Drain then boot:
  - Stimulus: fetch granted cycle t, boot_active rises t, boot_req at t+1 (addr 0x0, be=0001).
  - Required: no cpu_gnt after t; write appears on mem at t+2 or later; wr_count=1.
- Burst and overflow: 5 boot_req while in DRAIN with BUF_DEPTH=4 -> ovf_err=1; 4 writes committed in order; wr_count=4.
- Flush: boot_active falls with 3 entries queued -> 3 writes on consecutive cycles, then cpu_rst stays high for 16 cycles, then CPU regains the bus.
- Re-entry: boot_active rises during RELEASE -> back to BOOT, cpu_rst never deasserts, wr_count retained.

Source files
------------

// File: rtl/imem_boot_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_arb_pkg : shared types for the instruction-memory boot arbiter  |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
package imem_arb_pkg;

  localparam int ARB_AW = 32;
  localparam int ARB_DW = 32;
  localparam int ARB_BW = ARB_DW / 8;

  typedef enum logic [2:0] {
    CPU     = 3'd0,
    DRAIN   = 3'd1,
    BOOT    = 3'd2,
    FLUSH   = 3'd3,
    RELEASE = 3'd4
  } arb_state_t;

  typedef struct packed {
    logic [ARB_AW-1:0] addr;
    logic [ARB_DW-1:0] wdata;
    logic [ARB_BW-1:0] be;
  } boot_wr_t;

endpackage
`default_nettype wire

// File: rtl/imem_boot_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_boot_arbiter_if : boot-loader, CPU-fetch and memory bus bundle  |
// | Revision             : 1.0                                           |
// +----------------------------------------------------------------------+
interface imem_boot_arbiter_if
  import imem_arb_pkg::*;
#(
  parameter int AW = ARB_AW,
  parameter int DW = ARB_DW
) ();

  logic            boot_active;
  logic            boot_req;
  logic [AW-1:0]   boot_addr;
  logic [DW-1:0]   boot_wdata;
  logic [DW/8-1:0] boot_be;

  logic            cpu_req;
  logic [AW-1:0]   cpu_addr;
  logic            cpu_gnt;
  logic            cpu_rvalid;
  logic [DW-1:0]   cpu_rdata;

  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_be;
  logic [DW-1:0]   mem_rdata;

  // Arbiter side
  modport slave (
    input  boot_active, boot_req, boot_addr, boot_wdata, boot_be,
    input  cpu_req, cpu_addr, mem_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  // Environment side (boot loader, core and RAM)
  modport master (
    output boot_active, boot_req, boot_addr, boot_wdata, boot_be,
    output cpu_req, cpu_addr, mem_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

endinterface
`default_nettype wire

// File: rtl/imem_boot_arbiter_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo : single-clock FIFO, storage in flops, head read from regs |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int          PW       = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  always_comb begin
    full     = (cnt_q == FULL_CNT);
    empty    = (cnt_q == '0);
    do_pop   = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push onto a full FIFO is kept
    do_push  = push & (~full | do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + (PW+1)'(1);
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout = mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/imem_boot_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_boot_arbiter : hands the instruction RAM port between the CPU   |
// |                     fetch path and the UART boot loader              |
// | Revision          : 1.0                                              |
// +----------------------------------------------------------------------+
module imem_boot_arbiter
  import imem_arb_pkg::*;
#(
  parameter int AW        = ARB_AW,
  parameter int DW        = ARB_DW,
  parameter int BUF_DEPTH = 4,
  parameter int REL_CYC   = 16
) (
  input  logic                clk,
  input  logic                rst,
  imem_boot_arbiter_if.slave  bus,
  output logic                cpu_rst,
  output logic                ovf_err,
  output logic [31:0]         wr_count
);

  localparam int             BW       = DW / 8;
  localparam int             RCW      = (REL_CYC > 1) ? $clog2(REL_CYC) : 1;
  localparam logic [RCW-1:0] REL_LAST = RCW'(REL_CYC - 1);

  arb_state_t     state_q, state_d;
  logic [RCW-1:0] rel_cnt_q, rel_cnt_d;
  logic           cpu_rvalid_q, cpu_rvalid_d;
  logic           ovf_err_q, ovf_err_d;
  logic [31:0]    wr_count_q, wr_count_d;

  boot_wr_t push_data;
  boot_wr_t head;
  logic     fifo_pop, fifo_full, fifo_empty;

  assign push_data = {bus.boot_addr, bus.boot_wdata, bus.boot_be};

  sync_fifo #(
    .WIDTH ($bits(boot_wr_t)),
    .DEPTH (BUF_DEPTH)
  ) u_boot_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.boot_req),
    .pop   (fifo_pop),
    .din   (push_data),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d       = state_q;
    rel_cnt_d     = rel_cnt_q;
    wr_count_d    = wr_count_q;
    cpu_rvalid_d  = 1'b0;
    fifo_pop      = 1'b0;
    cpu_rst       = 1'b1;
    bus.cpu_gnt   = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = {AW{1'b0}};
    bus.mem_wdata = {DW{1'b0}};
    bus.mem_be    = {BW{1'b0}};

    case (state_q)
      CPU: begin
        cpu_rst      = 1'b0;
        bus.cpu_gnt  = bus.cpu_req;
        bus.mem_req  = bus.cpu_req;
        bus.mem_addr = bus.cpu_addr;
        cpu_rvalid_d = bus.cpu_req;
        if (bus.boot_active) begin
          state_d = DRAIN;
        end
      end

      // No grants are issued here, so the only read that can still be
      // outstanding returns during this cycle.
      DRAIN: begin
        state_d    = BOOT;
        wr_count_d = '0;
      end

      BOOT, FLUSH: begin
        fifo_pop = ~fifo_empty;
        if (fifo_pop) begin
          bus.mem_req   = 1'b1;
          bus.mem_we    = 1'b1;
          bus.mem_addr  = head.addr;
          bus.mem_wdata = head.wdata;
          bus.mem_be    = head.be;
          wr_count_d    = wr_count_q + 32'd1;
        end
        if (state_q == BOOT) begin
          if (!bus.boot_active) begin
            state_d = FLUSH;
          end
        end else if (bus.boot_active) begin
          state_d = BOOT;
        end else if (fifo_empty) begin
          state_d   = RELEASE;
          rel_cnt_d = '0;
        end
      end

      RELEASE: begin
        if (bus.boot_active) begin
          state_d   = BOOT;
          rel_cnt_d = '0;
        end else if (rel_cnt_q == REL_LAST) begin
          state_d   = CPU;
          rel_cnt_d = '0;
        end else begin
          rel_cnt_d = rel_cnt_q + RCW'(1);
        end
      end

      default: begin
        state_d   = RELEASE;
        rel_cnt_d = '0;
      end
    endcase

    ovf_err_d = ovf_err_q | (bus.boot_req & fifo_full & ~fifo_pop);
  end

  // Reset enters RELEASE so the core is held for REL_CYC cycles after power-on
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RELEASE;
      rel_cnt_q    <= '0;
      cpu_rvalid_q <= 1'b0;
      ovf_err_q    <= 1'b0;
      wr_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      rel_cnt_q    <= rel_cnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      ovf_err_q    <= ovf_err_d;
      wr_count_q   <= wr_count_d;
    end
  end

  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign ovf_err        = ovf_err_q;
  assign wr_count       = wr_count_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_imem_boot_arbiter : directed self-checking bench for the arbiter  |
// | Revision             : 1.0                                           |
// +----------------------------------------------------------------------+
module tb_imem_boot_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_rst;
  logic        ovf_err;
  logic [31:0] wr_count;
  int          n_cmp = 0;
  int          n_bad = 0;

  imem_boot_arbiter_if #(.AW(32), .DW(32)) bus ();

  imem_boot_arbiter #(
    .AW        (32),
    .DW        (32),
    .BUF_DEPTH (4),
    .REL_CYC   (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .cpu_rst  (cpu_rst),
    .ovf_err  (ovf_err),
    .wr_count (wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.boot_req   = 1'b1;
    bus.boot_addr  = a;
    bus.boot_wdata = d;
    bus.boot_be    = be;
  endtask

  initial begin
    rst             = 1'b1;
    bus.boot_active = 1'b0;
    bus.boot_req    = 1'b0;
    bus.boot_addr   = '0;
    bus.boot_wdata  = '0;
    bus.boot_be     = '0;
    bus.cpu_req     = 1'b0;
    bus.cpu_addr    = '0;
    bus.mem_rdata   = '0;

    // Reset for 3 cycles, then the 16-cycle release window
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    settle();
    chk1("rst_cpu_gnt", bus.cpu_gnt, 1'b0);
    chk1("rst_rvalid", bus.cpu_rvalid, 1'b0);
    chk1("rst_mem_we", bus.mem_we, 1'b0);
    chk1("rst_ovf", ovf_err, 1'b0);
    chk32("rst_wr_count", wr_count, 32'd0);
    for (int i = 0; i < 16; i++) begin
      chk1("rel_cpu_rst_hi", cpu_rst, 1'b1);
      chk1("rel_mem_req", bus.mem_req, 1'b0);
      tick();
      settle();
    end
    chk1("rel_cpu_rst_lo", cpu_rst, 1'b0);

    // CPU fetch
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 32'h0000_0100;
    settle();
    chk1("fetch_gnt", bus.cpu_gnt, 1'b1);
    chk1("fetch_mem_req", bus.mem_req, 1'b1);
    chk1("fetch_mem_we", bus.mem_we, 1'b0);
    chk32("fetch_mem_addr", bus.mem_addr, 32'h0000_0100);
    chk1("fetch_rvalid_early", bus.cpu_rvalid, 1'b0);
    tick();
    bus.cpu_req   = 1'b0;
    bus.mem_rdata = 32'hDEAD_BEEF;
    settle();
    chk1("fetch_rvalid", bus.cpu_rvalid, 1'b1);
    chk32("fetch_rdata", bus.cpu_rdata, 32'hDEAD_BEEF);
    chk1("fetch_gnt_idle", bus.cpu_gnt, 1'b0);
    tick();
    settle();
    chk1("fetch_rvalid_done", bus.cpu_rvalid, 1'b0);

    // Drain then boot: grant and boot_active in the same cycle t
    tick();
    bus.cpu_req     = 1'b1;
    bus.cpu_addr    = 32'h0000_0200;
    bus.boot_active = 1'b1;
    settle();
    chk1("drain_t_gnt", bus.cpu_gnt, 1'b1);
    chk1("drain_t_cpu_rst", cpu_rst, 1'b0);
    tick();
    push(32'h0, 32'h1122_3344, 4'b0001);
    bus.mem_rdata = 32'hCAFE_F00D;
    settle();
    chk1("drain_t1_gnt", bus.cpu_gnt, 1'b0);
    chk1("drain_t1_rvalid", bus.cpu_rvalid, 1'b1);
    chk32("drain_t1_rdata", bus.cpu_rdata, 32'hCAFE_F00D);
    chk1("drain_t1_cpu_rst", cpu_rst, 1'b1);
    chk1("drain_t1_mem_req", bus.mem_req, 1'b0);
    tick();
    bus.boot_req = 1'b0;
    settle();
    chk1("boot_t2_gnt", bus.cpu_gnt, 1'b0);
    chk1("boot_t2_mem_req", bus.mem_req, 1'b1);
    chk1("boot_t2_mem_we", bus.mem_we, 1'b1);
    chk32("boot_t2_addr", bus.mem_addr, 32'h0);
    chk32("boot_t2_wdata", bus.mem_wdata, 32'h1122_3344);
    chk32("boot_t2_be", 32'(bus.mem_be), 32'h1);
    chk32("boot_t2_wr_count", wr_count, 32'd0);
    tick();
    bus.cpu_req     = 1'b0;
    bus.boot_active = 1'b0;
    settle();
    chk32("boot_t3_wr_count", wr_count, 32'd1);
    chk1("boot_t3_mem_req", bus.mem_req, 1'b0);
    chk1("boot_t3_ovf", ovf_err, 1'b0);
    repeat (17) tick();
    settle();
    chk1("boot_rel_last_hi", cpu_rst, 1'b1);
    tick();
    settle();
    chk1("boot_rel_done", cpu_rst, 1'b0);

    // Burst of 5 writes with a 4-deep buffer: 4 queued in CPU, 5th in DRAIN
    for (int i = 0; i < 4; i++) begin
      tick();
      push(32'h10 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF);
      settle();
    end
    chk1("burst_ovf_pre", ovf_err, 1'b0);
    tick();
    bus.boot_req    = 1'b0;
    bus.boot_active = 1'b1;
    settle();
    chk1("burst_cpu_rst_u4", cpu_rst, 1'b0);
    tick();
    push(32'h20, 32'hA000_0004, 4'hF);
    settle();
    chk1("burst_drain_mem_req", bus.mem_req, 1'b0);
    tick();
    bus.boot_req = 1'b0;
    settle();
    chk1("burst_ovf", ovf_err, 1'b1);
    chk32("burst_w0_addr", bus.mem_addr, 32'h10);
    chk32("burst_w0_data", bus.mem_wdata, 32'hA000_0000);
    chk32("burst_w0_cnt", wr_count, 32'd0);
    // boot_active falls with 3 entries still queued
    tick();
    bus.boot_active = 1'b0;
    settle();
    chk1("flush_w1_req", bus.mem_req, 1'b1);
    chk32("flush_w1_addr", bus.mem_addr, 32'h14);
    chk32("flush_w1_cnt", wr_count, 32'd1);
    tick();
    settle();
    chk1("flush_w2_req", bus.mem_req, 1'b1);
    chk32("flush_w2_addr", bus.mem_addr, 32'h18);
    chk32("flush_w2_cnt", wr_count, 32'd2);
    tick();
    settle();
    chk1("flush_w3_req", bus.mem_req, 1'b1);
    chk32("flush_w3_addr", bus.mem_addr, 32'h1C);
    chk32("flush_w3_data", bus.mem_wdata, 32'hA000_0003);
    tick();
    settle();
    chk1("flush_end_req", bus.mem_req, 1'b0);
    chk32("flush_end_cnt", wr_count, 32'd4);
    chk1("flush_end_cpu_rst", cpu_rst, 1'b1);

    // Re-entry from RELEASE
    tick();
    tick();
    settle();
    chk1("reent_rel_cpu_rst", cpu_rst, 1'b1);
    tick();
    bus.boot_active = 1'b1;
    push(32'h40, 32'h5555_AAAA, 4'b0011);
    settle();
    chk1("reent_cpu_rst_a", cpu_rst, 1'b1);
    tick();
    bus.boot_req = 1'b0;
    settle();
    chk1("reent_mem_req", bus.mem_req, 1'b1);
    chk32("reent_addr", bus.mem_addr, 32'h40);
    chk32("reent_be", 32'(bus.mem_be), 32'h3);
    chk32("reent_cnt_kept", wr_count, 32'd4);
    chk1("reent_cpu_rst_b", cpu_rst, 1'b1);
    tick();
    bus.boot_active = 1'b0;
    settle();
    chk32("reent_cnt_inc", wr_count, 32'd5);
    chk1("reent_mem_idle", bus.mem_req, 1'b0);
    for (int i = 0; i < 17; i++) begin
      tick();
      settle();
      chk1("reent_rel_hi", cpu_rst, 1'b1);
    end
    tick();
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 32'h0000_0300;
    settle();
    chk1("reent_cpu_rst_lo", cpu_rst, 1'b0);
    chk1("reent_cpu_gnt", bus.cpu_gnt, 1'b1);
    chk32("reent_cpu_addr", bus.mem_addr, 32'h0000_0300);

    // Reset in the middle of BOOT discards queued writes
    tick();
    bus.cpu_req     = 1'b0;
    bus.boot_active = 1'b1;
    push(32'h80, 32'h8080_8080, 4'hF);
    settle();
    tick();
    push(32'h84, 32'h8484_8484, 4'hF);
    settle();
    chk1("mid_drain_req", bus.mem_req, 1'b0);
    tick();
    push(32'h88, 32'h8888_8888, 4'hF);
    settle();
    chk32("mid_boot_addr0", bus.mem_addr, 32'h80);
    tick();
    bus.boot_req    = 1'b0;
    bus.boot_active = 1'b0;
    rst             = 1'b1;
    settle();
    chk1("mid_boot_req1", bus.mem_req, 1'b1);
    chk32("mid_boot_addr1", bus.mem_addr, 32'h84);
    tick();
    rst = 1'b0;
    settle();
    chk1("mid_rst_mem_req", bus.mem_req, 1'b0);
    chk1("mid_rst_cpu_rst", cpu_rst, 1'b1);
    chk32("mid_rst_cnt", wr_count, 32'd0);
    chk1("mid_rst_ovf", ovf_err, 1'b0);
    for (int i = 0; i < 15; i++) begin
      tick();
      settle();
      chk1("mid_rel_hi", cpu_rst, 1'b1);
      chk1("mid_rel_mem", bus.mem_req, 1'b0);
    end
    tick();
    bus.boot_active = 1'b1;
    settle();
    chk1("mid_rel_done", cpu_rst, 1'b0);
    tick();
    tick();
    settle();
    chk1("mid_fifo_empty", bus.mem_req, 1'b0);
    chk32("mid_cnt_clear", wr_count, 32'd0);
    bus.boot_active = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
